// File: rtl/oam_dma_ctrl.sv
// Sprite DMA engine: a CPU write to the DMA register halts the CPU and copies
// one 256-byte page of CPU memory into PPU OAM. It takes one HALT cycle and an
// optional ALIGN cycle, then 256 READ/WRITE pairs. The total is 513 or 514
// cpu_ce cycles, depending on the CPU cycle parity.
module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
  parameter int          MEM_LATENCY  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_ce,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_data,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_data,
  output logic        cpu_halt,
  output logic        dma_busy,
  output logic        oam_dma,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_data_out
);

  // The READ/WRITE pairing assumes read data returns on the very next cpu_ce.
  generate
    if (MEM_LATENCY != 1) begin : g_bad_latency
      $error("oam_dma_ctrl: only MEM_LATENCY == 1 is supported");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] page, page_nxt;
  logic [7:0] idx, idx_nxt;
  logic       parity;
  logic       trigger;

  assign trigger = cpu_ce && cpu_wr && (cpu_addr == DMA_REG_ADDR) && (state == IDLE);

  // Next-state logic: every transition is qualified by cpu_ce.
  always_comb begin
    // NOTE: every variable gets a default first, so no path can leave one unassigned and infer a latch.
    state_nxt = state;
    page_nxt  = page;
    idx_nxt   = idx;
    if (cpu_ce) begin
      unique case (state)
        IDLE: begin
          if (trigger) begin
            state_nxt = HALT;
            page_nxt  = cpu_data;
            idx_nxt   = 8'h00;
          end
        end
        HALT:  state_nxt = parity ? ALIGN : READ;
        ALIGN: state_nxt = READ;
        READ:  state_nxt = WRITE;
        WRITE: begin
          if (idx == 8'hFF) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = READ;
            idx_nxt   = idx + 8'h01;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State, page, index and the free-running CPU parity flop.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state  <= IDLE;
      page   <= 8'h00;
      idx    <= 8'h00;
      parity <= 1'b0;
    end else begin
      state <= state_nxt;
      page  <= page_nxt;
      idx   <= idx_nxt;
      if (cpu_ce) begin
        parity <= ~parity;
      end
    end
  end

  // Outputs decode from the registered state, so they hold between cpu_ce pulses.
  // The OAM strobe is the one exception: it is confined to the cpu_ce clock of a WRITE.
  always_comb begin
    cpu_halt     = (state != IDLE);
    dma_busy     = (state != IDLE);
    mem_rd       = (state == READ);
    mem_addr     = (state == READ) ? {page, idx} : 16'h0000;
    oam_dma      = (state == WRITE) && cpu_ce;
    oam_addr     = (state == WRITE) ? idx : 8'h00;
    oam_data_out = (state == WRITE) ? mem_data : 8'h00;
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl. Memory model: byte at {p,i} = i ^ A5 ^ (p - 2).
module tb_oam_dma_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_ce;
  logic [15:0] cpu_addr;
  logic        cpu_wr;
  logic [7:0]  cpu_data;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data;
  logic        cpu_halt;
  logic        dma_busy;
  logic        oam_dma;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_data_out;

  int   checks = 0;
  int   fails  = 0;
  int   cyc_cnt = 0;
  logic par;

  oam_dma_ctrl #(.DMA_REG_ADDR(16'h4014), .MEM_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .cpu_ce(cpu_ce), .cpu_addr(cpu_addr),
    .cpu_wr(cpu_wr), .cpu_data(cpu_data), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_data(mem_data), .cpu_halt(cpu_halt), .dma_busy(dma_busy),
    .oam_dma(oam_dma), .oam_addr(oam_addr), .oam_data_out(oam_data_out)
  );

  always #5 clk = ~clk;

  // CPU bus memory: data for a read appears on the cpu_ce edge after mem_rd.
  always @(posedge clk) begin
    if (reset) mem_data <= 8'h00;
    else if (cpu_ce && mem_rd) mem_data <= mem_addr[7:0] ^ 8'hA5 ^ (mem_addr[15:8] - 8'h02);
  end

  // Reference CPU cycle parity (1 = odd cycle).
  always @(posedge clk) begin
    if (reset) par <= 1'b0;
    else if (cpu_ce) par <= ~par;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc_cnt++;
  endtask

  // Runs one transfer. want_align selects the 514-cycle case. inj_at >= 0 injects,
  // after that many OAM writes, either a reset (inj_reset) or a $4014 write of 8'h07.
  task automatic do_xfer(input logic [7:0] page, input int div, input bit want_align,
                         input int inj_at, input bit inj_reset, input string tag);
    int pulses = 0, halt_ce = 0, rd_pos = -1, data_err = 0, width_err = 0, addr_err = 0;
    int cycles = 0;
    bit started = 0, done = 0, triggered = 0, inj_done = 0;
    while (!done && cycles < 6000 && !(inj_reset && pulses == inj_at)) begin
      cpu_ce = (cyc_cnt % div == 0);
      cpu_wr = 1'b0; cpu_addr = 16'h0000; cpu_data = 8'h00;
      if (!triggered && cpu_ce && (par != want_align)) begin
        cpu_wr = 1'b1; cpu_addr = 16'h4014; cpu_data = page; triggered = 1;
      end else if (triggered && inj_at >= 0 && !inj_reset && !inj_done && pulses == inj_at && cpu_ce) begin
        cpu_wr = 1'b1; cpu_addr = 16'h4014; cpu_data = 8'h07; inj_done = 1;
      end
      @(negedge clk);
      if (mem_rd) begin
        if (rd_pos < 0) rd_pos = halt_ce;
        if (mem_addr !== {page, pulses[7:0]}) addr_err++;
      end
      if (cpu_ce && cpu_halt) halt_ce++;
      if (oam_dma) begin
        if (!cpu_ce) width_err++;
        if (oam_addr !== pulses[7:0] || oam_data_out !== (pulses[7:0] ^ 8'hA5 ^ (page - 8'h02)))
          data_err++;
        pulses++;
      end
      if (cpu_halt) started = 1;
      if (started && !cpu_halt && !dma_busy) done = 1;
      step();
      cycles++;
    end
    check({tag, " no_timeout"}, 32'(cycles < 6000), 32'd1);
    check({tag, " first_rd_delay"}, rd_pos, want_align ? 32'd2 : 32'd1);
    check({tag, " rd_addr_errs"}, addr_err, 32'd0);
    check({tag, " oam_data_errs"}, data_err, 32'd0);
    check({tag, " strobe_width_errs"}, width_err, 32'd0);
    if (inj_reset) begin
      cpu_ce = 1'b1; cpu_wr = 1'b0; reset = 1'b1;
      step();
      reset = 1'b0;
      @(negedge clk);
      check({tag, " rst cpu_halt"}, 32'(cpu_halt), 32'd0);
      check({tag, " rst oam_dma"}, 32'(oam_dma), 32'd0);
      check({tag, " rst dma_busy"}, 32'(dma_busy), 32'd0);
      check({tag, " rst mem_rd"}, 32'(mem_rd), 32'd0);
      step();
    end else begin
      check({tag, " halt_cycles"}, halt_ce, want_align ? 32'd514 : 32'd513);
      check({tag, " oam_pulses"}, pulses, 32'd256);
      check({tag, " halt_low_after"}, 32'(cpu_halt), 32'd0);
    end
  endtask

  // Free-running idle: the CPU must never be halted.
  task automatic idle_run(input int n, input string tag);
    int halts = 0;
    cpu_ce = 1'b1; cpu_wr = 1'b0; cpu_addr = 16'h0000;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (cpu_halt || dma_busy) halts++;
      step();
    end
    check({tag, " no_restart"}, halts, 32'd0);
  endtask

  initial begin
    reset = 1'b1; cpu_ce = 1'b1; cpu_addr = 16'h0000; cpu_wr = 1'b0; cpu_data = 8'h00;
    step(); step();
    @(negedge clk);
    check("reset cpu_halt", 32'(cpu_halt), 32'd0);
    check("reset dma_busy", 32'(dma_busy), 32'd0);
    check("reset mem_rd", 32'(mem_rd), 32'd0);
    check("reset mem_addr", 32'(mem_addr), 32'd0);
    check("reset oam_dma", 32'(oam_dma), 32'd0);
    check("reset oam_addr", 32'(oam_addr), 32'd0);
    check("reset oam_data_out", 32'(oam_data_out), 32'd0);
    step();
    reset = 1'b0;

    // Neighbouring registers must not trigger.
    cpu_wr = 1'b1; cpu_addr = 16'h4013; cpu_data = 8'h02; step();
    cpu_addr = 16'h4015; step();
    cpu_wr = 1'b0; cpu_addr = 16'h0000; step(); step();
    @(negedge clk);
    check("miss cpu_halt", 32'(cpu_halt), 32'd0);
    check("miss dma_busy", 32'(dma_busy), 32'd0);
    check("miss mem_rd", 32'(mem_rd), 32'd0);
    check("miss oam_dma", 32'(oam_dma), 32'd0);
    check("miss mem_addr", 32'(mem_addr), 32'd0);
    step();

    do_xfer(8'h02, 1, 1'b0, -1, 1'b0, "even_div1");
    do_xfer(8'h02, 1, 1'b1, -1, 1'b0, "odd_div1");
    do_xfer(8'h02, 3, 1'b0, -1, 1'b0, "even_div3");
    do_xfer(8'h02, 3, 1'b1, -1, 1'b0, "odd_div3");
    do_xfer(8'h02, 1, 1'b0, 40, 1'b0, "busy_write");
    idle_run(30, "busy_write");
    do_xfer(8'h02, 1, 1'b1, 100, 1'b1, "mid_reset");
    do_xfer(8'h03, 1, 1'b0, -1, 1'b0, "after_reset_p3");

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
